// File: rtl/accel_spi_reader.sv
// SPI mode-3 master for an ADXL345-class accelerometer: one POWER_CTL write after reset,
// then periodic burst reads of DATAX0/DATAX1 delivered as data_x with a one-cycle strobe.
module accel_spi_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 500000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [15:0] data_x,
    output logic        data_update,
    output logic        busy
);

    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [15:0]      INIT_WORD  = 16'h2D08;
    localparam logic [15:0]      READ_CMD   = 16'hF200;
    localparam logic [5:0]       INIT_LAST  = 6'd32;
    localparam logic [5:0]       READ_LAST  = 6'd48;
    localparam logic [5:0]       RX_FIRST   = 6'd18;
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {RST_GAP, INIT, GAP, WAIT, READ, UPDATE} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       phase;
    logic [15:0]      tx_sh;
    logic [15:0]      rx_sh;
    logic [TMR_W-1:0] timer;

    logic in_frame, half_end, frame_end, gap_end, start_read;

    // phase 0 is the setup half-period; phase 2i+1 / 2i+2 are the low / high halves of bit i
    assign in_frame   = (state == INIT) || (state == READ);
    assign half_end   = (div_cnt == HALF_LAST);
    assign frame_end  = in_frame && half_end &&
                        (phase == ((state == READ) ? READ_LAST : INIT_LAST));
    assign gap_end    = (div_cnt == GAP_LAST);
    assign start_read = (state == WAIT) && (timer == '0) && enable;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= RST_GAP;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        spi_cs_n    = 1'b1;
        busy        = 1'b0;
        spi_sclk    = 1'b1;
        spi_mosi    = 1'b0;
        data_update = 1'b0;
        case (state)
            RST_GAP: if (gap_end) state_nxt = INIT;
            INIT, READ: begin
                spi_cs_n = 1'b0;
                busy     = 1'b1;
                spi_sclk = ~phase[0];
                spi_mosi = (phase != 6'd0) && tx_sh[15];
                if (frame_end) state_nxt = (state == READ) ? UPDATE : GAP;
            end
            GAP:     if (gap_end) state_nxt = WAIT;
            WAIT:    if (start_read) state_nxt = READ;
            UPDATE: begin
                data_update = 1'b1;
                state_nxt   = GAP;
            end
            default: state_nxt = RST_GAP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (state_nxt != state) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (in_frame && half_end) begin
            div_cnt <= '0;
            phase   <= phase + 6'd1;
        end else if (state == WAIT) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // TX advances at the end of each high half so MOSI changes with the falling SCLK edge
    always_ff @(posedge clock) begin
        if (state == RST_GAP && state_nxt == INIT)
            tx_sh <= INIT_WORD;
        else if (start_read)
            tx_sh <= READ_CMD;
        else if (in_frame && half_end && !phase[0] && phase != 6'd0)
            tx_sh <= {tx_sh[14:0], 1'b0};
    end

    // only data bits 8..23 are kept; the command-phase MISO bits are ignored
    always_ff @(posedge clock) begin
        if (state == READ && div_cnt == '0 && !phase[0] && phase >= RX_FIRST)
            rx_sh <= {rx_sh[14:0], spi_miso};
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            data_x <= '0;
        else if (state == READ && frame_end)
            data_x <= {rx_sh[7:0], rx_sh[15:8]};
    end

    // timer parks at zero, which doubles as the latched "sample due" flag
    always_ff @(posedge clock) begin
        if (!reset_n)
            timer <= '0;
        else if (start_read)
            timer <= TMR_RELOAD;
        else if (timer != '0)
            timer <= timer - TMR_W'(1);
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: behavioural SPI slave/frame decoder with randomized sample data.
module tb_accel_spi_reader;

    localparam int CD = 2;
    localparam int SP = 200;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_sclk, spi_cs_n, spi_mosi, data_update, busy;
    logic [15:0] data_x;

    accel_spi_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .spi_miso(spi_miso),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .data_x(data_x), .data_update(data_update), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle)", tag, got, exp);
        end
    endtask

    int cyc = 0;
    initial forever @(posedge clock) cyc++;

    // slave / monitor state shared with the stimulus process
    logic [7:0] slave_x0 = 8'h00, slave_x1 = 8'h00;
    int  n_frames = 0, n_reads = 0, n_inits = 0, n_upd_seen = 0;
    int  f_bits = 0, t_rel = 0;
    logic f_init = 1'b1, in_read = 1'b0;
    int  read_starts[$];
    int  v_sclk = 0, v_mosi0 = 0, v_busy = 0, v_upd2 = 0, v_mstab = 0, v_hold = 0;

    initial begin : slave_mon
        logic p_cs, p_sclk, p_mosi, p_upd, p_rst, abort, upd_due, expect_init;
        logic [15:0] p_dx, exp_x;
        logic [23:0] miso_word;
        logic [31:0] f_mosi;
        logic [7:0]  f_x0, f_x1;
        int f_start;
        p_cs = 1'b1; p_sclk = 1'b1; p_mosi = 1'b0; p_upd = 1'b0; p_rst = 1'b0;
        p_dx = '0; expect_init = 1'b1; miso_word = '0; f_mosi = '0;
        f_x0 = '0; f_x1 = '0; f_start = 0; exp_x = '0;
        forever begin
            @(negedge clock);
            abort = !p_rst;
            if (abort) expect_init = 1'b1;
            if (spi_cs_n && !spi_sclk) v_sclk++;
            if (spi_cs_n && spi_mosi) v_mosi0++;
            if (busy == spi_cs_n) v_busy++;
            if (p_upd && data_update) v_upd2++;
            if (!p_sclk && spi_sclk && !spi_cs_n && spi_mosi != p_mosi) v_mstab++;
            if (data_update) n_upd_seen++;
            if (p_cs && !spi_cs_n) begin
                f_start = cyc; f_bits = 0; f_mosi = '0; f_init = expect_init;
                f_x0 = slave_x0; f_x1 = slave_x1;
                miso_word = {8'($urandom), f_x0, f_x1};
            end
            if (!spi_cs_n && p_sclk && !spi_sclk && f_bits < 24)
                spi_miso = miso_word[23 - f_bits];
            if (!spi_cs_n && !p_sclk && spi_sclk) begin
                f_mosi = {f_mosi[30:0], spi_mosi};
                f_bits++;
            end
            upd_due = 1'b0;
            if (!p_cs && spi_cs_n && !abort) begin
                n_frames++;
                if (f_init) begin
                    chk("init_bits", f_bits, 16);
                    chk("init_mosi", f_mosi, 32'h0000_2D08);
                    chk("init_len", cyc - f_start, 33 * CD);
                    chk("init_delay", f_start - t_rel, 2 * CD);
                    n_inits++;
                    expect_init = 1'b0;
                end else begin
                    chk("rd_bits", f_bits, 24);
                    chk("rd_mosi", f_mosi, 32'h00F2_0000);
                    chk("rd_len", cyc - f_start, 49 * CD);
                    read_starts.push_back(f_start);
                    exp_x = {f_x1, f_x0};
                    upd_due = 1'b1;
                end
            end
            if (upd_due) begin
                chk("upd_strobe", 32'(data_update), 1);
                chk("data_x", 32'(data_x), 32'(exp_x));
                n_reads++;
            end else if (data_update) begin
                chk("upd_spurious", 32'(data_update), 0);
            end
            if (data_x != p_dx && !upd_due && !abort) v_hold++;
            in_read = !spi_cs_n && !f_init;
            p_cs = spi_cs_n; p_sclk = spi_sclk; p_mosi = spi_mosi;
            p_upd = data_update; p_rst = reset_n; p_dx = data_x;
        end
    end

    initial begin : stim
        int n, r0, f0, u0, i0, t_en;
        // reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cs_n", 32'(spi_cs_n), 1);
        chk("rst_sclk", 32'(spi_sclk), 1);
        chk("rst_mosi", 32'(spi_mosi), 0);
        chk("rst_data_x", 32'(data_x), 0);
        chk("rst_upd", 32'(data_update), 0);
        chk("rst_busy", 32'(busy), 0);

        // release with enable low: INIT only
        @(posedge clock); #1;
        reset_n = 1'b1; t_rel = cyc;
        @(negedge clock);
        chk("rel_cs_n", 32'(spi_cs_n), 1);
        chk("rel_sclk", 32'(spi_sclk), 1);
        n = 0;
        while (n < 400) begin @(posedge clock); n++; end
        chk("init_only_frames", n_frames, 1);
        chk("init_only_inits", n_inits, 1);

        // first read
        #1; slave_x0 = 8'h34; slave_x1 = 8'h12; enable = 1'b1;
        n = 0;
        while (n_reads < 1 && n < 400) begin @(posedge clock); n++; end
        chk("read1_done", n_reads, 1);
        chk("read1_x", 32'(data_x), 32'h1234);

        // negative value and cadence
        #1; slave_x0 = 8'hF0; slave_x1 = 8'hFF;
        n = 0;
        while (n_reads < 2 && n < 400) begin @(posedge clock); n++; end
        chk("neg_x", 32'(data_x), 32'hFFF0);
        n = 0;
        while (n_reads < 6 && n < 1500) begin @(posedge clock); n++; end
        chk("cadence_reads", n_reads, 6);
        for (int i = 1; i < read_starts.size(); i++)
            chk("cadence", read_starts[i] - read_starts[i-1], SP);

        // random sample values
        for (int k = 0; k < 3; k++) begin
            #1; slave_x0 = 8'($urandom); slave_x1 = 8'($urandom);
            r0 = n_reads; n = 0;
            while (n_reads < r0 + 1 && n < 400) begin @(posedge clock); n++; end
            chk("rand_read", n_reads, r0 + 1);
        end

        // enable drop at bit 10
        n = 0;
        while (!(in_read && f_bits == 10) && n < 600) begin @(posedge clock); n++; end
        chk("drop_reached", 32'(in_read && f_bits == 10), 1);
        #1; r0 = n_reads; f0 = n_frames; u0 = n_upd_seen; enable = 1'b0;
        repeat (500) @(posedge clock);
        chk("drop_reads", n_reads, r0 + 1);
        chk("drop_frames", n_frames, f0 + 1);
        chk("drop_upd", n_upd_seen, u0 + 1);
        #1; enable = 1'b1; t_en = cyc;
        n = 0;
        while (n_frames < f0 + 2 && n < 300) begin @(posedge clock); n++; end
        chk("reen_frames", n_frames, f0 + 2);
        if (read_starts.size() > 0)
            chk("reen_start", read_starts[read_starts.size()-1] - t_en, 1);

        // reset in the middle of a read
        n = 0;
        while (!(in_read && f_bits == 15) && n < 600) begin @(posedge clock); n++; end
        chk("mid_reached", 32'(in_read && f_bits == 15), 1);
        #1; reset_n = 1'b0; i0 = n_inits; r0 = n_reads;
        @(posedge clock);
        @(negedge clock);
        chk("mid_cs_n", 32'(spi_cs_n), 1);
        chk("mid_sclk", 32'(spi_sclk), 1);
        chk("mid_upd", 32'(data_update), 0);
        chk("mid_data_x", 32'(data_x), 0);
        repeat (2) @(posedge clock);
        #1; reset_n = 1'b1; t_rel = cyc;
        n = 0;
        while (n_reads < r0 + 1 && n < 600) begin @(posedge clock); n++; end
        chk("post_rst_read", n_reads, r0 + 1);
        chk("post_rst_init", n_inits, i0 + 1);

        repeat (20) @(posedge clock);
        chk("viol_sclk_idle", v_sclk, 0);
        chk("viol_mosi_idle", v_mosi0, 0);
        chk("viol_busy", v_busy, 0);
        chk("viol_upd_double", v_upd2, 0);
        chk("viol_mosi_stable", v_mstab, 0);
        chk("viol_data_hold", v_hold, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

- Upstream front end of the smoothing path; owns the SPI link to the ADXL345-class accelerometer.
- After reset it runs one configuration write to put the sensor in measurement mode.
- It then periodically burst-reads the X-axis data registers.
- Each assembled 16-bit sample goes out on `data_x` with a one-cycle `data_update` strobe, the exact pair the smoothing filter consumes.

## Interface
- CLK_DIV, 25: `clock` cycles per SCLK half-period (≥2). Default gives 1 MHz SCLK at 50 MHz.
- SAMPLE_PERIOD, 500000: `clock` cycles between successive read starts. Default gives 100 Hz. Constraint: ≥ CLK_DIV*51.
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  high: periodic reads allowed; low: no new reads start
- spi_miso  in  1  sensor serial data out
- spi_sclk  out  1  SPI clock, mode 3 (idles high)
- spi_cs_n  out  1  chip select, active low
- spi_mosi  out  1  serial data to sensor, MSB first
- data_x  out  16  last X sample {DATAX1, DATAX0}, two's complement as delivered
- data_update  out  1  one-cycle strobe: `data_x` holds a new sample this cycle
- busy  out  1  high while `spi_cs_n` is low

## Operation
- Reset values, while reset_n=0 and on the first cycle after release:
  - spi_sclk=1, spi_cs_n=1, spi_mosi=0, data_x=0, data_update=0, busy=0.
  - State is RST_GAP.
- States and transitions:
  - RST_GAP: wait 2*CLK_DIV cycles → INIT.
  - INIT: 16-bit write frame 0x2D08 (POWER_CTL=0x08, measure). Runs regardless of `enable` → GAP.
  - GAP: cs_n high for 2*CLK_DIV cycles → WAIT.
  - WAIT: idle until the sample timer expires and enable=1 → READ.
  - READ: 24-bit frame.
    - MOSI sends command 0xF2 (read, multibyte, address 0x32), then 16 zero bits.
    - MISO bits 8..15 are DATAX0; bits 16..23 are DATAX1.
    - → UPDATE.
  - UPDATE: single cycle; `data_x` loaded, `data_update`=1 → GAP.
- Sample timer:
  - Free-running down-counter, reloaded with SAMPLE_PERIOD-1 at each READ start.
  - The first READ starts on the first WAIT cycle after INIT's GAP.
  - Timer expired while enable=0: expiry stays latched; READ starts on the first WAIT cycle with enable=1.
- enable falling during READ: frame and UPDATE complete normally; no further READ.
- Shift registers: 16-bit TX shift, 16-bit RX shift. The MISO command-phase bits (0..7) are discarded.
- Reset mid-frame: on the reset cycle, cs_n=1, sclk=1, no `data_update`, partial RX discarded. After release the sequence restarts at RST_GAP (INIT repeated).

## Timing
- Frame start = cycle T0, where cs_n goes low and busy goes high.
- Setup phase: sclk high during T0 … T0+CLK_DIV-1.
- For bit i (0-based, N bits):
  - sclk low from T0+CLK_DIV*(2i+1) for CLK_DIV cycles. MOSI changes on that first low cycle.
  - sclk high from T0+CLK_DIV*(2i+2) for CLK_DIV cycles.
  - MISO is sampled on the first high cycle, i.e. the SCLK rising edge.
- cs_n and busy return high at T0+CLK_DIV*(2N+1). sclk is already high.
- Low time of cs_n:
  - CLK_DIV*33 for INIT.
  - CLK_DIV*49 for READ.
- data_update:
  - Asserted on cycle T0+CLK_DIV*49 (UPDATE), exactly one cycle.
  - data_x changes only on that cycle and holds until the next UPDATE.
- mosi=0 whenever cs_n=1.
- Read start spacing with enable steadily high: exactly SAMPLE_PERIOD cycles.

## Test plan
- Reset/init:
  - Setup: CLK_DIV=2, SAMPLE_PERIOD=200; release reset_n with enable=0.
  - Required: outputs equal the reset values.
  - Required: after 4 cycles cs_n low for 66 cycles; MOSI decodes 0x2D08; no READ frame follows while enable=0.
- Sample read:
  - Stimulus: enable=1; slave model returns DATAX0=0x34, DATAX1=0x12.
  - Required: MOSI command 0xF2; cs_n low 98 cycles; data_update one-cycle pulse on the cs_n rising cycle with data_x=0x1234.
- Negative value and cadence:
  - Stimulus: slave returns 0xF0, 0xFF.
  - Required: data_x=0xFFF0; successive cs_n falling edges exactly 200 cycles apart over 5 reads.
- enable drop mid-frame:
  - Stimulus: enable=0 at bit 10 of a READ.
  - Required: frame completes, data_update fires once, no further frames.
  - Stimulus: enable=1 after timer expiry.
  - Required: READ starts the next cycle.
- Reset mid-READ:
  - Stimulus: reset_n=0 at bit 15.
  - Required: next cycle cs_n=1, sclk=1, data_update=0, data_x=0; after release INIT 0x2D08 repeats before any READ.
- Mode-3 check:
  - Assertions: sclk=1 whenever cs_n=1; mosi stable across every sclk rising edge; data_update never high two consecutive cycles.
